frame_cmd_issuer: RTL

Hardware initiator for the command-word interface of the convolution file register; it produces the 32-bit words that the soft processor would otherwise write to gpo0. It selects the kernel, packs an incoming pixel stream three pixels per word, issues `LOAD_FRAME`/`END_FRAME`, polls `IS_FRAME_READY`, then reads the result back with `GET_FRAME` and emits the readback words on an output stream. It is used for processor-less bring-up and for self-checking benches.

---
 rtl/fr_cmd_pkg.sv | 27 ++
 rtl/pix3_packer.sv | 44 ++++
 rtl/frame_cmd_issuer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fr_cmd_pkg.sv
// Command-word encoding shared by the frame issuer and the convolution file register.
// The issuer state type lives here as well.
package fr_cmd_pkg;

   localparam int OP_KERNEL_SEL     = 0;
   localparam int OP_LOAD_FRAME     = 1;
   localparam int OP_END_FRAME      = 2;
   localparam int OP_IS_FRAME_READY = 3;
   localparam int OP_GET_FRAME      = 4;

   localparam int STROBE_BIT = 23;
   localparam int OPCODE_LSB = 24;

   typedef enum logic [3:0] {
      S_IDLE,
      S_KSEL,
      S_GATHER,
      S_SEND,
      S_POLL,
      S_POLL_WAIT,
      S_GET,
      S_GET_WAIT,
      S_PUSH,
      S_DONE
   } issuer_state_t;

endpackage

// File: rtl/pix3_packer.sv
// Three-slot pixel packer: fills slots low-to-high and releases a word when full or flushed.
// Slots clear after every released word, so a short tail is zero-padded.
module pix3_packer #(
   parameter int NB_PIX = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  flush,
   input  logic [NB_PIX-1:0]     pix,
   output logic [3*NB_PIX-1:0]   word,
   output logic                  word_ready
);

   logic [3*NB_PIX-1:0] slots_q;
   logic [1:0]          count_q;

   // word already contains the pixel being pushed this cycle
   always_comb begin
      word = slots_q;
      if (push) begin
         word[int'(count_q) * NB_PIX +: NB_PIX] = pix;
      end
   end

   assign word_ready = push && ((count_q == 2'd2) || flush);

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         slots_q <= '0;
         count_q <= '0;
      end else if (push) begin
         if (word_ready) begin
            slots_q <= '0;
            count_q <= '0;
         end else begin
            slots_q <= word;
            count_q <= count_q + 2'd1;
         end
      end
   end

endmodule

// File: rtl/frame_cmd_issuer.sv
// Hardware initiator for the convolution file register command port: kernel select,
// packed frame load, ready polling and GET_FRAME readback onto an output stream.
module frame_cmd_issuer
   import fr_cmd_pkg::*;
#(
   parameter int NB_INST   = 32,
   parameter int NB_C0M    = 8,
   parameter int NB_PIX    = 7,
   parameter int FRAME_PIX = 1024,
   parameter int OUT_WORDS = 256,
   parameter int RESP_WAIT = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_start,
   input  logic [1:0]         i_kernel_sel,
   input  logic [NB_PIX-1:0]  i_pix_data,
   input  logic               i_pix_valid,
   output logic               o_pix_ready,
   output logic [NB_INST-1:0] o_cmd_to_fr,
   input  logic [NB_INST-1:0] i_data_from_fr,
   output logic [NB_INST-1:0] o_out_data,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int PAY_W  = 3 * NB_PIX;
   localparam int PIX_W  = $clog2(FRAME_PIX + 1);
   localparam int OUT_W  = $clog2(OUT_WORDS + 1);
   localparam int WAIT_W = $clog2(RESP_WAIT + 1);

   issuer_state_t     state;
   logic              phase;
   logic              last_word;
   logic [PIX_W-1:0]  pix_cnt;
   logic [OUT_W-1:0]  out_cnt;
   logic [WAIT_W-1:0] wait_cnt;

   logic              pix_accept;
   logic              last_pix;
   logic              packer_clear;
   logic [PAY_W-1:0]  pack_word;
   logic              word_ready;

   function automatic logic [NB_INST-1:0] cmd_word(input int op, input logic [PAY_W-1:0] payload);
      logic [NB_INST-1:0] w;
      w = '0;
      w[OPCODE_LSB +: NB_C0M] = NB_C0M'(op);
      w[PAY_W-1:0] = payload;
      return w;
   endfunction

   assign pix_accept   = i_pix_valid && o_pix_ready;
   assign last_pix     = (pix_cnt == PIX_W'(FRAME_PIX - 1));
   assign packer_clear = (state == S_IDLE);

   pix3_packer #(
      .NB_PIX(NB_PIX)
   ) u_packer (
      .clock     (clock),
      .reset     (reset),
      .clear     (packer_clear),
      .push      (pix_accept),
      .flush     (last_pix),
      .pix       (i_pix_data),
      .word      (pack_word),
      .word_ready(word_ready)
   );

   // Every command is SETUP (phase 0, strobe low) then ASSERT (phase 1, strobe high);
   // the word for the next command is loaded on the edge that leaves the previous state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         phase       <= 1'b0;
         last_word   <= 1'b0;
         pix_cnt     <= '0;
         out_cnt     <= '0;
         wait_cnt    <= '0;
         o_cmd_to_fr <= '0;
         o_pix_ready <= 1'b0;
         o_out_data  <= '0;
         o_out_valid <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               o_cmd_to_fr <= '0;
               phase       <= 1'b0;
               last_word   <= 1'b0;
               pix_cnt     <= '0;
               out_cnt     <= '0;
               wait_cnt    <= '0;
               if (i_start) begin
                  state       <= S_KSEL;
                  o_busy      <= 1'b1;
                  o_cmd_to_fr <= cmd_word(OP_KERNEL_SEL, PAY_W'(i_kernel_sel));
               end
            end
            S_KSEL: begin
               phase <= ~phase;
               if (!phase) begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b1;
               end else begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b0;
                  o_pix_ready             <= 1'b1;
                  state                   <= S_GATHER;
               end
            end
            S_GATHER: begin
               if (pix_accept) begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
                  if (word_ready) begin
                     o_pix_ready <= 1'b0;
                     last_word   <= last_pix;
                     o_cmd_to_fr <= cmd_word(last_pix ? OP_END_FRAME : OP_LOAD_FRAME, pack_word);
                     state       <= S_SEND;
                  end
               end
            end
            S_SEND: begin
               phase <= ~phase;
               if (!phase) begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b1;
               end else if (last_word) begin
                  o_cmd_to_fr <= cmd_word(OP_IS_FRAME_READY, '0);
                  state       <= S_POLL;
               end else begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b0;
                  o_pix_ready             <= 1'b1;
                  state                   <= S_GATHER;
               end
            end
            S_POLL: begin
               phase <= ~phase;
               if (!phase) begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b1;
               end else begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b0;
                  wait_cnt                <= '0;
                  state                   <= S_POLL_WAIT;
               end
            end
            S_POLL_WAIT: begin
               if (wait_cnt == WAIT_W'(RESP_WAIT - 1)) begin
                  wait_cnt <= '0;
                  if (i_data_from_fr[0]) begin
                     o_cmd_to_fr <= cmd_word(OP_GET_FRAME, '0);
                     state       <= S_GET;
                  end else begin
                     o_cmd_to_fr <= cmd_word(OP_IS_FRAME_READY, '0);
                     state       <= S_POLL;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_GET: begin
               phase <= ~phase;
               if (!phase) begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b1;
               end else begin
                  o_cmd_to_fr[STROBE_BIT] <= 1'b0;
                  wait_cnt                <= '0;
                  state                   <= S_GET_WAIT;
               end
            end
            S_GET_WAIT: begin
               if (wait_cnt == WAIT_W'(RESP_WAIT - 1)) begin
                  wait_cnt    <= '0;
                  o_out_data  <= i_data_from_fr;
                  o_out_valid <= 1'b1;
                  state       <= S_PUSH;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_PUSH: begin
               if (o_out_valid && i_out_ready) begin
                  o_out_valid <= 1'b0;
                  out_cnt     <= out_cnt + OUT_W'(1);
                  if (out_cnt == OUT_W'(OUT_WORDS - 1)) begin
                     o_done <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     o_cmd_to_fr <= cmd_word(OP_GET_FRAME, '0);
                     state       <= S_GET;
                  end
               end
            end
            S_DONE: begin
               o_busy      <= 1'b0;
               o_cmd_to_fr <= '0;
               state       <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
